// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - register map, response codes and shared helpers for the multichannel RNG
package rng_pkg;
    localparam int W_CTRL   = 0;
    localparam int W_STATUS = 1;
    localparam int W_RAND   = 2;
    localparam int W_COUNT  = 3;
    localparam int W_THRESH = 4;
    localparam int W_SEED0  = 8;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_SEED_LOAD   = 1;
    localparam int STATUS_UNDERFLOW = 16;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction
endpackage

// File: rtl/rng_lfsr_ch.sv
// rtl/rng_lfsr_ch.sv - one Galois LFSR channel with seed load and step enable
module rng_lfsr_ch
    import rng_pkg::*;
#(
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] step_val
);
    logic [31:0] state_q, state_d;

    // step_val depends only on the stored state so the top can gate step with it loop-free
    assign step_val = state_q[0] ? ((state_q >> 1) ^ POLY) : (state_q >> 1);

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = step_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 32'd1;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: rtl/rng_axil_multich.sv
// rtl/rng_axil_multich.sv - AXI4-Lite RNG: NUM_CH XORed LFSRs feeding a popped-on-read FIFO
module rng_axil_multich
    import rng_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] POLY       = DEFAULT_POLY,
    parameter int          ADDR_W     = 6
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic              ctrl_en_q, ctrl_en_d, seed_load_q, seed_load_d;
    logic [8:0]        thresh_q, thresh_d;
    logic [31:0]       count_q, count_d;
    logic              underflow_q, underflow_d;
    logic [31:0]       seed_q [NUM_CH];
    logic [31:0]       seed_d [NUM_CH];
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [31:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              irq_q, irq_d;

    logic              wr_acc, rd_acc, push, pop, fifo_empty, fifo_full, seed_hit;
    logic [31:0]       gen_word;
    logic [31:0]       ch_next [NUM_CH];
    int                widx, ridx;
    logic              unused_addr_bits;

    assign wr_acc     = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !ARESET;
    assign rd_acc     = S_AXI_ARVALID && !rvalid_q && !ARESET;
    assign widx       = int'(S_AXI_AWADDR[ADDR_W-1:2]);
    assign ridx       = int'(S_AXI_ARADDR[ADDR_W-1:2]);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        rng_lfsr_ch #(.POLY(POLY)) u_ch (
            .clk(ACLK), .rst(ARESET), .load(seed_load_q), .step(push),
            .seed(seed_q[k]), .step_val(ch_next[k])
        );
    end

    always_comb begin
        gen_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gen_word = gen_word ^ ch_next[k];
        end
    end

    always_comb begin
        ctrl_en_d = ctrl_en_q;  seed_load_d = 1'b0;    thresh_d = thresh_q;
        count_d = count_q;      underflow_d = underflow_q;
        seed_d = seed_q;        fifo_d = fifo_q;
        bvalid_d = bvalid_q;    bresp_d = bresp_q;
        rvalid_d = rvalid_q;    rresp_d = rresp_q;     rdata_d = rdata_q;
        wr_ptr_d = wr_ptr_q;    rd_ptr_d = rd_ptr_q;   level_d = level_q;
        pop = 1'b0;             push = 1'b0;           seed_hit = 1'b0;

        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (wr_acc) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (widx)
                W_CTRL: if (S_AXI_WSTRB[0]) begin
                    ctrl_en_d   = S_AXI_WDATA[CTRL_EN];
                    seed_load_d = S_AXI_WDATA[CTRL_SEED_LOAD];
                end
                W_STATUS: if (S_AXI_WSTRB[STATUS_UNDERFLOW/8] && S_AXI_WDATA[STATUS_UNDERFLOW])
                    underflow_d = 1'b0;
                W_THRESH: begin
                    if (S_AXI_WSTRB[0]) thresh_d[7:0] = S_AXI_WDATA[7:0];
                    if (S_AXI_WSTRB[1]) thresh_d[8]   = S_AXI_WDATA[8];
                end
                default: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (widx == W_SEED0 + k) begin
                            seed_hit  = 1'b1;
                            seed_d[k] = apply_strb(seed_q[k], S_AXI_WDATA, S_AXI_WSTRB);
                            if (seed_d[k] == 32'd0) seed_d[k] = 32'd1;
                        end
                    end
                    if (!seed_hit) bresp_d = RESP_SLVERR;
                end
            endcase
        end

        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (rd_acc) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (ridx)
                W_CTRL:   rdata_d = {31'b0, ctrl_en_q};
                W_STATUS: rdata_d = {15'b0, underflow_q, 8'(level_q), 6'b0, fifo_full, fifo_empty};
                W_RAND: begin
                    // Placed after the W1C handling so a same-cycle underflow set wins over the clear
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        rdata_d = fifo_q[rd_ptr_q];
                    end
                end
                W_COUNT:  rdata_d = count_q;
                W_THRESH: rdata_d = {23'b0, thresh_q};
                default: begin
                    rresp_d = RESP_SLVERR;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ridx == W_SEED0 + k) begin
                            rresp_d = RESP_OKAY;
                            rdata_d = seed_q[k];
                        end
                    end
                end
            endcase
        end

        push = ctrl_en_q && !seed_load_q && (!fifo_full || pop);
        if (seed_load_q) begin
            wr_ptr_d = '0; rd_ptr_d = '0; level_d = '0; count_d = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = gen_word;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_q + 32'd1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (!push && pop) level_d = level_q - LVL_W'(1);
        end

        irq_d = (thresh_q != 9'd0) && (32'(level_q) >= {23'b0, thresh_q});
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_en_q <= 1'b0;  seed_load_q <= 1'b0;  thresh_q <= '0;    count_q <= '0;
            underflow_q <= 1'b0;
            bvalid_q <= 1'b0;   bresp_q <= '0;        rvalid_q <= 1'b0;  rresp_q <= '0;
            rdata_q <= '0;      wr_ptr_q <= '0;       rd_ptr_q <= '0;    level_q <= '0;
            irq_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) seed_q[k] <= 32'd1;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            ctrl_en_q <= ctrl_en_d;  seed_load_q <= seed_load_d;  thresh_q <= thresh_d;
            count_q <= count_d;      underflow_q <= underflow_d;
            bvalid_q <= bvalid_d;    bresp_q <= bresp_d;  rvalid_q <= rvalid_d;  rresp_q <= rresp_d;
            rdata_q <= rdata_d;      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; level_q <= level_d;
            irq_q <= irq_d;
            seed_q <= seed_d;
            fifo_q <= fifo_d;
        end
    end

    assign S_AXI_AWREADY = wr_acc;
    assign S_AXI_WREADY  = wr_acc;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = rd_acc;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_rng_axil_multich.sv
// tb/tb_rng_axil_multich.sv - directed bench for rng_axil_multich with 1- and 2-channel instances
module tb_rng_axil_multich;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;

    logic        ACLK = 1'b0, ARESET = 1'b1, sel = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

    logic        awready1, wready1, bvalid1, arready1, rvalid1, irq1;
    logic        awready2, wready2, bvalid2, arready2, rvalid2, irq2;
    logic [1:0]  bresp1, rresp1, bresp2, rresp2;
    logic [31:0] rdata1, rdata2;

    logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m, irq_m;
    logic [1:0]  bresp_m, rresp_m;
    logic [31:0] rdata_m;

    int n_vec = 0, n_err = 0;

    always #5 ACLK = ~ACLK;

    rng_axil_multich #(.NUM_CH(1), .FIFO_DEPTH(16), .POLY(32'h80200003), .ADDR_W(6)) dut1 (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready1),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready1),
        .S_AXI_BRESP(bresp1), .S_AXI_BVALID(bvalid1), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready1),
        .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1), .S_AXI_RVALID(rvalid1), .S_AXI_RREADY(rready),
        .irq(irq1));

    rng_axil_multich #(.NUM_CH(2), .FIFO_DEPTH(16), .POLY(32'h80200003), .ADDR_W(6)) dut2 (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready2),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready2),
        .S_AXI_BRESP(bresp2), .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready2),
        .S_AXI_RDATA(rdata2), .S_AXI_RRESP(rresp2), .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready),
        .irq(irq2));

    assign awready_m = sel ? awready2 : awready1;
    assign wready_m  = sel ? wready2  : wready1;
    assign bvalid_m  = sel ? bvalid2  : bvalid1;
    assign bresp_m   = sel ? bresp2   : bresp1;
    assign arready_m = sel ? arready2 : arready1;
    assign rvalid_m  = sel ? rvalid2  : rvalid1;
    assign rresp_m   = sel ? rresp2   : rresp1;
    assign rdata_m   = sel ? rdata2   : rdata1;
    assign irq_m     = sel ? irq2     : irq1;

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
        int  n;
        bit  got;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            got = awready_m && wready_m;
            @(posedge ACLK); #1;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'b11;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            if (bvalid_m) begin got = 1'b1; resp = bresp_m; end
            n++;
        end
        bready = 1'b1;
        @(posedge ACLK); #1;
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp);
        int  n;
        bit  got;
        araddr = a; arvalid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            got = arready_m;
            @(posedge ACLK); #1;
            n++;
        end
        arvalid = 1'b0;
        data = 32'hDEADBEEF; resp = 2'b11;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            if (rvalid_m) begin got = 1'b1; data = rdata_m; resp = rresp_m; end
            n++;
        end
        rready = 1'b1;
        @(posedge ACLK); #1;
        rready = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_wr(a, d, s, r);
        chk({name, "_bresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(a, d, r);
        chk({name, "_rdata"}, d, exp_d);
        chk({name, "_rresp"}, 32'(r), 32'(exp_resp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          n;
        bit          got;
        logic [1:0]  r;
        logic [31:0] d;

        tbl.push_back('{1'b0, 6'h04, 32'h0,        4'h0, 32'h00000001, OK});
        tbl.push_back('{1'b0, 6'h20, 32'h0,        4'h0, 32'h00000001, OK});
        tbl.push_back('{1'b0, 6'h0C, 32'h0,        4'h0, 32'h00000000, OK});
        tbl.push_back('{1'b0, 6'h00, 32'h0,        4'h0, 32'h00000000, OK});
        tbl.push_back('{1'b0, 6'h08, 32'h0,        4'h0, 32'h00000000, OK});
        tbl.push_back('{1'b0, 6'h04, 32'h0,        4'h0, 32'h00010001, OK});
        tbl.push_back('{1'b1, 6'h04, 32'h00010000, 4'hB, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h04, 32'h0,        4'h0, 32'h00010001, OK});
        tbl.push_back('{1'b1, 6'h04, 32'h00010000, 4'hF, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h04, 32'h0,        4'h0, 32'h00000001, OK});
        tbl.push_back('{1'b1, 6'h10, 32'h000001FF, 4'h1, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h10, 32'h0,        4'h0, 32'h000000FF, OK});
        tbl.push_back('{1'b1, 6'h10, 32'h00000100, 4'h2, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h10, 32'h0,        4'h0, 32'h000001FF, OK});
        tbl.push_back('{1'b1, 6'h10, 32'h00000000, 4'hF, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h10, 32'h0,        4'h0, 32'h00000000, OK});
        tbl.push_back('{1'b1, 6'h0C, 32'h00000005, 4'hF, 32'h0,        SE});
        tbl.push_back('{1'b0, 6'h0C, 32'h0,        4'h0, 32'h00000000, OK});
        tbl.push_back('{1'b1, 6'h08, 32'h00000005, 4'hF, 32'h0,        SE});
        tbl.push_back('{1'b0, 6'h24, 32'h0,        4'h0, 32'h00000000, SE});
        tbl.push_back('{1'b0, 6'h15, 32'h0,        4'h0, 32'h00000000, SE});
        tbl.push_back('{1'b0, 6'h07, 32'h0,        4'h0, 32'h00000001, OK});
        tbl.push_back('{1'b1, 6'h20, 32'h00000000, 4'hF, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h20, 32'h0,        4'h0, 32'h00000001, OK});
        tbl.push_back('{1'b1, 6'h20, 32'h12345678, 4'h3, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h20, 32'h0,        4'h0, 32'h00005678, OK});
        tbl.push_back('{1'b1, 6'h20, 32'h00000001, 4'hF, 32'h0,        OK});
        tbl.push_back('{1'b1, 6'h00, 32'h00000002, 4'hF, 32'h0,        OK});
        tbl.push_back('{1'b0, 6'h00, 32'h0,        4'h0, 32'h00000000, OK});

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("reset_outputs", 32'({irq_m, bvalid_m, rvalid_m, arready_m, awready_m}), 32'h0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                axi_wr(tbl[i].addr, tbl[i].wdata, tbl[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
            end else begin
                axi_rd(tbl[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].exp);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
            end
        end

        // single-channel sequence from seed 1
        wr_chk("seq_ctrl3", 6'h00, 32'h3, 4'hF, OK);
        repeat (20) @(posedge ACLK);
        #1;
        rd_chk("seq_rand0", 6'h08, 32'h80200003, OK);
        rd_chk("seq_rand1", 6'h08, 32'hC0300002, OK);
        rd_chk("seq_rand2", 6'h08, 32'h60180001, OK);

        // threshold interrupt and saturation
        wr_chk("thr_flush", 6'h00, 32'h2, 4'hF, OK);
        wr_chk("thr_set8", 6'h10, 32'h8, 4'hF, OK);
        @(negedge ACLK);
        chk("irq_low_empty", 32'(irq_m), 32'h0);
        wr_chk("thr_en", 6'h00, 32'h1, 4'hF, OK);
        n = 0;
        while (!irq_m && n < 60) begin
            @(negedge ACLK);
            n++;
        end
        chk("irq_rise", 32'(irq_m), 32'h1);
        repeat (30) @(posedge ACLK);
        #1;
        rd_chk("sat_status", 6'h04, 32'h00001002, OK);
        rd_chk("sat_count", 6'h0C, 32'd16, OK);
        wr_chk("thr_17", 6'h10, 32'd17, 4'hF, OK);
        repeat (2) @(negedge ACLK);
        chk("irq_thr17", 32'(irq_m), 32'h0);
        wr_chk("thr_16", 6'h10, 32'd16, 4'hF, OK);
        repeat (2) @(negedge ACLK);
        chk("irq_thr16", 32'(irq_m), 32'h1);
        wr_chk("thr_0", 6'h10, 32'd0, 4'hF, OK);
        repeat (2) @(negedge ACLK);
        chk("irq_thr0", 32'(irq_m), 32'h0);
        rd_chk("full_pop", 6'h08, 32'h80200003, OK);
        rd_chk("full_pop_status", 6'h04, 32'h00001002, OK);
        rd_chk("full_pop_count", 6'h0C, 32'd17, OK);

        // drain to level 5 with generation halted, then reset mid write-response
        wr_chk("halt", 6'h00, 32'h0, 4'hF, OK);
        rd_chk("halt_head", 6'h08, 32'hC0300002, OK);
        for (int i = 0; i < 10; i++) begin
            axi_rd(6'h08, d, r);
            chk($sformatf("drain%0d_rresp", i), 32'(r), 32'(OK));
        end
        rd_chk("lvl5_status", 6'h04, 32'h00000500, OK);
        awaddr = 6'h10; wdata = 32'd3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            got = awready_m;
            @(posedge ACLK); #1;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("bvalid_held", 32'(bvalid_m), 32'h1);
        chk("irq_lvl5_thr3", 32'(irq_m), 32'h1);
        #2 ARESET = 1'b1;
        #1;
        chk("async_reset_drop", 32'({bvalid_m, irq_m}), 32'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        rd_chk("post_reset_status", 6'h04, 32'h00000001, OK);
        rd_chk("post_reset_thresh", 6'h10, 32'h00000000, OK);

        // two-channel instance
        sel = 1'b1;
        rd_chk("ch2_unmapped", 6'h28, 32'h0, SE);
        wr_chk("ch2_wr_count", 6'h0C, 32'h5, 4'hF, SE);
        wr_chk("ch2_seed1_zero", 6'h24, 32'h0, 4'hF, OK);
        rd_chk("ch2_seed1_one", 6'h24, 32'h1, OK);
        wr_chk("ch2_seed1_two", 6'h24, 32'h2, 4'hF, OK);
        rd_chk("ch2_seed1_rb", 6'h24, 32'h2, OK);
        wr_chk("ch2_ctrl3", 6'h00, 32'h3, 4'hF, OK);
        repeat (20) @(posedge ACLK);
        #1;
        rd_chk("ch2_rand0", 6'h08, 32'h80200002, OK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
